// File: rtl/result_deskew_reader_if.sv
// Row stream from result_deskew_reader to the host/compare logic.
// The producer drives row_valid/row_data/row_idx/mat_idx; the consumer drives row_ready.
interface result_deskew_reader_if #(
  parameter int unsigned ARRAY_SIZE     = 8,
  parameter int unsigned OUT_DATA_WIDTH = 16
);
  localparam int unsigned RowW = ARRAY_SIZE * OUT_DATA_WIDTH;
  localparam int unsigned IdxW = $clog2(ARRAY_SIZE);

  logic            row_valid;
  logic            row_ready;
  logic [RowW-1:0] row_data;
  logic [IdxW-1:0] row_idx;
  logic [1:0]      mat_idx;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    output mat_idx,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    input  mat_idx,
    output row_ready
  );
endinterface

// File: rtl/result_deskew_reader.sv
// Drains the diagonal-packed result banks c0/c1/c2 and streams each matrix row-major.
// Each bank address k holds anti-diagonal i+j=k; it is unpacked into an 8x8 buffer and
// the buffer is then presented one row per valid/ready handshake.
module result_deskew_reader #(
  parameter int unsigned ARRAY_SIZE     = 8,
  parameter int unsigned OUT_DATA_WIDTH = 16,
  parameter int unsigned NUM_MAT        = 3
) (
  input  logic                                 clk,
  input  logic                                 srstn,
  input  logic                                 start,
  output logic [5:0]                           sram_raddr_c,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c0,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c1,
  input  logic [ARRAY_SIZE*OUT_DATA_WIDTH-1:0] sram_rdata_c2,
  result_deskew_reader_if.master               row_if,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned W       = OUT_DATA_WIDTH;
  localparam int unsigned RowW    = ARRAY_SIZE * W;
  localparam int unsigned NumDiag = 2 * ARRAY_SIZE - 1;
  localparam int unsigned CntW    = $clog2(NumDiag + 1);
  localparam int unsigned IdxW    = $clog2(ARRAY_SIZE);

  typedef enum logic [1:0] {StIdle, StRead, StStream, StFin} state_e;

  state_e          state_q, state_d;
  // READ phase counter: 0..NumDiag-1 issue addresses, NumDiag waits for the last capture.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cap_en_q;
  logic [CntW-1:0] cap_addr_q;
  logic [IdxW-1:0] row_q, row_d;
  logic [1:0]      mat_q, mat_d;
  logic [W-1:0]    buf_q [ARRAY_SIZE][ARRAY_SIZE];
  logic [RowW-1:0] rdata_sel;

  // Slot of element (i,j) inside the word for diagonal i+j. Short (upper-left) diagonals
  // are right-aligned into the top slots, so the slot depends on j; long ones on i.
  function automatic int unsigned slot_of(input int unsigned i, input int unsigned j);
    return (i + j < ARRAY_SIZE) ? (ARRAY_SIZE - 1 - j) : i;
  endfunction

  // Bank select follows the matrix currently being drained.
  always_comb begin
    case (mat_q)
      2'd0:    rdata_sel = sram_rdata_c0;
      2'd1:    rdata_sel = sram_rdata_c1;
      default: rdata_sel = sram_rdata_c2;
    endcase
  end

  // Next-state, counters and control outputs.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    row_d            = row_q;
    mat_d            = mat_q;
    sram_raddr_c     = '0;
    row_if.row_valid = 1'b0;
    busy             = (state_q != StIdle);
    done             = (state_q == StFin);
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRead;
          cnt_d   = '0;
          row_d   = '0;
          mat_d   = 2'd0;
        end
      end
      StRead: begin
        if (cnt_q < CntW'(NumDiag)) begin
          sram_raddr_c = 6'(cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NumDiag)) begin
          state_d = StStream;
          cnt_d   = '0;
        end
      end
      StStream: begin
        row_if.row_valid = 1'b1;
        if (row_if.row_ready) begin
          if (row_q == IdxW'(ARRAY_SIZE - 1)) begin
            row_d = '0;
            if (mat_q < 2'(NUM_MAT - 1)) begin
              mat_d   = mat_q + 2'd1;
              state_d = StRead;
            end else begin
              state_d = StFin;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Row data is only driven while streaming so idle/read cycles show zeros.
  always_comb begin
    row_if.row_data = '0;
    if (state_q == StStream) begin
      for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
        row_if.row_data[j*W +: W] = buf_q[row_q][j];
      end
    end
  end

  assign row_if.row_idx = row_q;
  assign row_if.mat_idx = mat_q;

  // FSM state and counters.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      mat_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      mat_q   <= mat_d;
    end
  end

  // Tracks which address's data arrives from the SRAM this cycle (one-cycle read latency).
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      cap_en_q   <= 1'b0;
      cap_addr_q <= '0;
    end else begin
      cap_en_q   <= (state_q == StRead) && (cnt_q < CntW'(NumDiag));
      cap_addr_q <= cnt_q;
    end
  end

  // Scatter the returned diagonal into the row buffer; unused slots are never read.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
        for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
          buf_q[i][j] <= '0;
        end
      end
    end else if (cap_en_q) begin
      for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
        for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
          if (cap_addr_q == CntW'(i + j)) begin
            buf_q[i][j] <= rdata_sel[slot_of(i, j)*W +: W];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_result_deskew_reader.sv
// Bench for result_deskew_reader: SRAM bank model, diagonal packer and row scoreboard.
module tb_result_deskew_reader;

  typedef struct packed {
    logic [1:0]   mat;
    logic [2:0]   row;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         srstn = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   raddr;
  logic [127:0] rd0, rd1, rd2;
  logic         busy, done;

  logic [15:0]  cmat [3][8][8];
  logic [127:0] mem  [3][64];
  exp_t         sb [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  result_deskew_reader_if row_if ();

  result_deskew_reader dut (
    .clk           (clk),
    .srstn         (srstn),
    .start         (start),
    .sram_raddr_c  (raddr),
    .sram_rdata_c0 (rd0),
    .sram_rdata_c1 (rd1),
    .sram_rdata_c2 (rd2),
    .row_if        (row_if),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM banks: data one cycle after the address.
  always @(posedge clk) begin
    rd0 <= mem[0][raddr];
    rd1 <= mem[1][raddr];
    rd2 <= mem[2][raddr];
  end

  // Pack every matrix by anti-diagonal; unused slots carry 0xFFFF junk.
  task automatic load_banks();
    logic [127:0] word;
    int n, imin, s;
    for (int m = 0; m < 3; m++) begin
      for (int k = 0; k < 15; k++) begin
        word = {8{16'hFFFF}};
        n    = (k < 8) ? k + 1 : 15 - k;
        imin = (k < 8) ? 0 : k - 7;
        for (int mm = 0; mm < n; mm++) begin
          s = 8 - n + mm;
          word[16*s +: 16] = cmat[m][imin+mm][k-imin-mm];
        end
        mem[m][k] = word;
      end
    end
  endtask

  task automatic set_basic();
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        cmat[0][i][j] = 16'(8 * i + j);
        cmat[1][i][j] = 16'(-(8 * i + j));
        cmat[2][i][j] = 16'(100 + i);
      end
    end
    load_banks();
  endtask

  task automatic push_expected();
    exp_t e;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 8; i++) begin
        e.mat = 2'(m);
        e.row = 3'(i);
        for (int j = 0; j < 8; j++) e.data[16*j +: 16] = cmat[m][i][j];
        sb.push_back(e);
      end
    end
  endtask

  // Starts one drain, pushes its expected rows and checks every handshake as it happens.
  task automatic run_drain(input bit stall, input bit poke, output int done_cyc,
                           output int stalls);
    exp_t         e;
    logic [127:0] held_data;
    logic [2:0]   held_idx;
    bit           was_stalled;
    int           first_valid;
    push_expected();
    done_cyc    = -1;
    stalls      = 0;
    was_stalled = 1'b0;
    first_valid = -1;
    held_data   = '0;
    held_idx    = '0;
    @(posedge clk); #1;
    start            = 1'b1;
    row_if.row_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_before_start: busy=%b done=%b required 0 0", busy, done);
    end
    for (int c = 1; c < 400; c++) begin
      @(posedge clk); #1;
      start            = poke && (c == 5 || c == 40);
      row_if.row_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      @(negedge clk);
      if (c <= 15) begin
        n_checks++;
        if (raddr !== 6'(c - 1)) begin
          n_fail++;
          $display("FAIL raddr_seq cycle %0d: got %0d required %0d", c, raddr, c - 1);
        end
      end
      if (!done) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_during_run cycle %0d: got %b required 1", c, busy);
        end
      end
      if (row_if.row_valid) begin
        if (first_valid < 0) first_valid = c;
        n_checks++;
        if (raddr !== 6'd0) begin
          n_fail++;
          $display("FAIL raddr_while_streaming cycle %0d: got %0d required 0", c, raddr);
        end
        if (was_stalled) begin
          n_checks++;
          if (row_if.row_data !== held_data || row_if.row_idx !== held_idx) begin
            n_fail++;
            $display("FAIL stall_stable cycle %0d: got row %0d %h required row %0d %h",
                     c, row_if.row_idx, row_if.row_data, held_idx, held_data);
          end
        end
        if (row_if.row_ready) begin
          was_stalled = 1'b0;
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL row_extra cycle %0d: got row %0d mat %0d required none",
                     c, row_if.row_idx, row_if.mat_idx);
          end else begin
            e = sb.pop_front();
            if (row_if.row_data !== e.data || row_if.row_idx !== e.row ||
                row_if.mat_idx !== e.mat) begin
              n_fail++;
              $display("FAIL row_data cycle %0d: got m%0d r%0d %h required m%0d r%0d %h", c,
                       row_if.mat_idx, row_if.row_idx, row_if.row_data, e.mat, e.row, e.data);
            end
          end
        end else begin
          stalls++;
          was_stalled = 1'b1;
          held_data   = row_if.row_data;
          held_idx    = row_if.row_idx;
        end
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    n_checks++;
    if (done_cyc < 0) begin
      n_fail++;
      $display("FAIL done_timeout: got no done within 400 cycles required done");
    end
    n_checks++;
    if (first_valid != 17) begin
      n_fail++;
      $display("FAIL first_row_cycle: got %0d required 17", first_valid);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rows_missing: got %0d left required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if (raddr !== 6'd0 || row_if.row_valid !== 1'b0 || row_if.row_data !== 128'd0 ||
        row_if.row_idx !== 3'd0 || row_if.mat_idx !== 2'd0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got a=%0d v=%b d=%h r=%0d m=%0d b=%b dn=%b required all 0", tag,
               raddr, row_if.row_valid, row_if.row_data, row_if.row_idx, row_if.mat_idx,
               busy, done);
    end
  endtask

  task automatic test_reset();
    srstn            = 1'b0;
    row_if.row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_values");
    srstn = 1'b1;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic_drain();
    int dc, st;
    set_basic();
    run_drain(1'b0, 1'b0, dc, st);
    n_checks++;
    if (dc != 73) begin
      n_fail++;
      $display("FAIL basic_done_cycle: got %0d required 73", dc);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after_done: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_backpressure();
    int dc, st;
    set_basic();
    run_drain(1'b1, 1'b0, dc, st);
    n_checks++;
    if (st == 0 || dc != 73 + st) begin
      n_fail++;
      $display("FAIL bp_done_cycle: got %0d (stalls %0d) required %0d", dc, st, 73 + st);
    end
  endtask

  task automatic test_boundary();
    int dc, st;
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 8; i++) begin
        for (int j = 0; j < 8; j++) cmat[m][i][j] = 16'($urandom());
      end
      cmat[m][0][0] = 16'h8000;
      cmat[m][7][7] = 16'h7FFF;
      cmat[m][0][7] = 16'h7FFF;
      cmat[m][7][0] = 16'h8000;
    end
    load_banks();
    run_drain(1'b0, 1'b0, dc, st);
    n_checks++;
    if (dc != 73) begin
      n_fail++;
      $display("FAIL boundary_done_cycle: got %0d required 73", dc);
    end
  endtask

  task automatic test_start_while_busy();
    int dc, st;
    set_basic();
    run_drain(1'b0, 1'b1, dc, st);
    n_checks++;
    if (dc != 73) begin
      n_fail++;
      $display("FAIL busy_start_done_cycle: got %0d required 73", dc);
    end
  endtask

  task automatic test_reset_mid_drain();
    int dc, st;
    bit hit;
    set_basic();
    hit = 1'b0;
    @(posedge clk); #1;
    start            = 1'b1;
    row_if.row_ready = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (row_if.row_valid && row_if.mat_idx == 2'd1 && row_if.row_idx == 3'd3) begin
        hit = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL mid_drain_reach: got no matrix 1 row 3 required it within 200 cycles");
    end
    srstn = 1'b0;
    #1;
    check_all_zero("reset_abort");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_all_zero("held_in_reset");
    end
    srstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_all_zero("no_done_after_abort");
    end
    run_drain(1'b0, 1'b0, dc, st);
    n_checks++;
    if (dc != 73) begin
      n_fail++;
      $display("FAIL restart_done_cycle: got %0d required 73", dc);
    end
  endtask

  task automatic test_back_to_back();
    int dc1, dc2, st;
    set_basic();
    run_drain(1'b0, 1'b0, dc1, st);
    run_drain(1'b0, 1'b0, dc2, st);
    n_checks++;
    if (dc1 != 73 || dc2 != 73) begin
      n_fail++;
      $display("FAIL b2b_done_cycles: got %0d %0d required 73 73", dc1, dc2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_boundary();
    test_start_while_busy();
    test_reset_mid_drain();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
